// File: rtl/yc_column_io_pkg.sv
// yc_column_io_pkg: dual-rail codes, FSM states and timing constants for the column bridge
package yc_column_io_pkg;
  localparam logic [1:0] V_EMPTY = 2'b00;
  localparam logic [1:0] V_0     = 2'b01;
  localparam logic [1:0] V_1     = 2'b10;
  localparam logic [1:0] V_ILL   = 2'b11;
  localparam int RST_CYCLES = 4;
  typedef enum logic [2:0] {
    S_RST,
    S_IDLE,
    S_WFULL,
    S_RESULT,
    S_WEMPTY,
    S_ERR
  } state_t;
endpackage

// File: rtl/yc_dr_sync.sv
// yc_dr_sync: SYNC-deep single-bit synchronizer with asynchronous active-low clear
module yc_dr_sync #(
  parameter int SYNC = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);
  logic [SYNC-1:0] r_sh;
  // shift the asynchronous bit through the flop chain
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_sh <= '0;
    else r_sh <= {r_sh[SYNC-2:0], i_d};
  assign o_q = r_sh[SYNC-1];
endmodule

// File: rtl/yc_column_io.sv
// yc_column_io: clocked-to-four-phase dual-rail bridge driving the tops of a row of cell columns
module yc_column_io
  import yc_column_io_pkg::*;
#(
  parameter int W       = 8,
  parameter int SYNC    = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           err,
  output logic           array_reset,
  output logic [W-1:0]   uempty,
  output logic [2*W-1:0] uin,
  input  logic [2*W-1:0] uout
);
  localparam int CW = $clog2(TIMEOUT);
  state_t         r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic [W-1:0]   r_data, w_data_nxt, r_out, w_out_nxt, w_dec;
  logic [2*W-1:0] r_uin, w_uin_nxt, w_sync, r_prev, w_enc;
  logic           r_err;
  logic           w_all_full, w_all_empty, w_any_ill, w_stable;

  for (genvar g = 0; g < 2*W; g++) begin : g_sync
    yc_dr_sync #(.SYNC(SYNC)) u_sync (
      .clk    (clk),
      .reset_n(reset_n),
      .i_d    (uout[g]),
      .o_q    (w_sync[g])
    );
  end

  // classify synced column pairs and build the encoded/decoded words
  always_comb begin
    w_all_full  = 1'b1;
    w_all_empty = 1'b1;
    w_any_ill   = 1'b0;
    w_dec       = '0;
    w_enc       = '0;
    for (int i = 0; i < W; i++) begin
      w_all_full  = w_all_full & (w_sync[2*i+:2] == V_0 || w_sync[2*i+:2] == V_1);
      w_all_empty = w_all_empty & (w_sync[2*i+:2] == V_EMPTY);
      w_any_ill   = w_any_ill | (w_sync[2*i+:2] == V_ILL);
      w_dec[i]    = w_sync[2*i+:2] == V_1;
      w_enc[2*i+:2] = r_data[i] ? V_1 : V_0;
    end
    w_stable = w_sync == r_prev;
  end

  // next-state, wait counter and registered-output next values
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    w_out_nxt   = r_out;
    w_uin_nxt   = r_uin;
    case (r_state)
      S_RST: begin
        w_state_nxt = (r_cnt == CW'(RST_CYCLES-1)) ? S_WEMPTY : S_RST;
        w_cnt_nxt   = (r_cnt == CW'(RST_CYCLES-1)) ? '0 : r_cnt + 1'b1;
      end
      S_IDLE: begin
        if (in_valid) begin
          w_data_nxt  = in_data;
          w_state_nxt = S_WFULL;
          w_cnt_nxt   = '0;
        end
      end
      S_WFULL: begin
        w_uin_nxt = w_enc;
        if (w_all_full && w_stable) begin
          w_out_nxt   = w_dec;
          w_state_nxt = S_RESULT;
        end else if (r_cnt == CW'(TIMEOUT-1)) w_state_nxt = S_ERR;
        else w_cnt_nxt = r_cnt + 1'b1;
      end
      S_RESULT: begin
        if (out_ready) begin
          w_uin_nxt   = '0;
          w_state_nxt = S_WEMPTY;
          w_cnt_nxt   = '0;
        end
      end
      S_WEMPTY: begin
        w_uin_nxt = '0;
        if (w_all_empty && w_stable) w_state_nxt = S_IDLE;
        else if (r_cnt == CW'(TIMEOUT-1)) w_state_nxt = S_ERR;
        else w_cnt_nxt = r_cnt + 1'b1;
      end
      S_ERR:   w_uin_nxt = '0;
      default: w_state_nxt = S_ERR;
    endcase
    if (r_state != S_RST && w_any_ill) w_state_nxt = S_ERR;
    if (w_state_nxt == S_ERR) w_uin_nxt = '0;
  end

  // state, counter, datapath and sticky error registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= S_RST;
      r_cnt   <= '0;
      r_data  <= '0;
      r_out   <= '0;
      r_uin   <= '0;
      r_prev  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
      r_out   <= w_out_nxt;
      r_uin   <= w_uin_nxt;
      r_prev  <= w_sync;
      r_err   <= r_err | (w_state_nxt == S_ERR);
    end

  assign in_ready    = r_state == S_IDLE;
  assign out_valid   = r_state == S_RESULT;
  assign out_data    = r_out;
  assign err         = r_err;
  assign array_reset = r_state == S_RST || r_state == S_ERR;
  assign uempty      = '0;
  assign uin         = r_uin;
endmodule

// File: tb/tb_yc_column_io.sv
// tb_yc_column_io: randomized scoreboard bench with a delayed-echo column model
module tb_yc_column_io;
  localparam int W = 8, SYNC = 2, TO = 64;
  logic clk = 0, reset_n = 0, in_valid = 0, out_ready = 0;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid, err, array_reset;
  logic [W-1:0] out_data, uempty;
  logic [2*W-1:0] uin, uout = '0;
  int n_tests = 0, n_fail = 0;
  logic [W-1:0] sb[$];
  logic [W-1:0] mon_exp;
  int dly[W];
  int stuck = -1, inject = -1, cyc = 0;
  logic [2*W-1:0] hist[64];

  yc_column_io #(.W(W), .SYNC(SYNC), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .err(err), .array_reset(array_reset),
    .uempty(uempty), .uin(uin), .uout(uout)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] enc(logic [W-1:0] d);
    logic [2*W-1:0] r;
    for (int i = 0; i < W; i++) r[2*i+:2] = d[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_delays(int lo, int hi);
    for (int i = 0; i < W; i++) dly[i] = $urandom_range(hi, lo);
    for (int j = 0; j < 64; j++) hist[j] = '0;
  endtask

  task automatic wait_ready(string nm);
    int k = 0;
    while (!in_ready && k < 400) begin tick(1); k++; end
    chk(nm, in_ready, 1);
  endtask

  task automatic send(logic [W-1:0] d);
    wait_ready("ready_before_send");
    in_data  = d;
    in_valid = 1;
    @(posedge clk);
    sb.push_back(d);
    #1 in_valid = 0;
  endtask

  task automatic wait_valid(string nm, output int k);
    k = 0;
    while (!out_valid && k < 400) begin tick(1); k++; end
    chk(nm, out_valid, 1);
  endtask

  // column model: each column echoes its uin pair after dly[i] cycles
  initial forever begin
    @(posedge clk);
    #2;
    hist[cyc % 64] = uin;
    for (int i = 0; i < W; i++)
      uout[2*i+:2] = (i == stuck) ? 2'b00 : (i == inject) ? 2'b11 : hist[(cyc + 64 - dly[i]) % 64][2*i+:2];
    cyc++;
  end

  // scoreboard monitor: compare each result as the host takes it
  initial forever begin
    @(negedge clk);
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        mon_exp = sb.pop_front();
        chk("out_data", out_data, mon_exp);
        chk("uin_during_result", uin, enc(mon_exp));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [W-1:0] d;
    for (int i = 0; i < W; i++) dly[i] = 10;
    for (int j = 0; j < 64; j++) hist[j] = '0;
    #23;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_array_reset", array_reset, 1);
    chk("rst_uin", uin, 0);
    chk("rst_err", err, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_uempty", uempty, 0);
    tick(1);
    reset_n = 1;
    wait_ready("ready_after_reset");
    // reset in the middle of a full wait
    for (int i = 0; i < W; i++) dly[i] = 30;
    send(8'h3C);
    tick(5);
    reset_n = 0;
    sb.delete();
    #1;
    chk("midrst_uin", uin, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_array_reset", array_reset, 1);
    tick(2);
    reset_n = 1;
    k = 0;
    while (array_reset && k < 20) begin tick(1); k++; end
    chk("array_reset_cycles", k, 4);
    wait_ready("ready_after_midrst");
    // fixed word A5
    set_delays(10, 10);
    out_ready = 1;
    send(8'hA5);
    tick(1);
    chk("uin_A5", uin, 16'h9966);
    wait_ready("ready_after_A5");
    // randomized words, delays and host back-pressure
    repeat (12) begin
      set_delays(1, 20);
      out_ready = 0;
      d = W'($urandom);
      send(d);
      tick(1);
      chk("uin_rand", uin, enc(d));
      wait_valid("valid_rand", k);
      tick($urandom_range(4, 0));
      out_ready = 1;
      tick(1);
      out_ready = 0;
    end
    // staggered column arrival
    wait_ready("ready_before_stagger");
    set_delays(1, 20);
    dly[0] = 3;
    dly[7] = 40;
    send(8'h81);
    wait_valid("valid_stagger", k);
    chk("stagger_no_early", k >= 40 + SYNC + 2, 1);
    out_ready = 1;
    tick(1);
    out_ready = 0;
    // long result hold
    wait_ready("ready_before_hold");
    set_delays(5, 5);
    d = W'($urandom);
    send(d);
    wait_valid("valid_hold", k);
    for (int r = 0; r < 5; r++) begin
      tick(10);
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, d);
      chk("hold_uin", uin, enc(d));
      chk("hold_err", err, 0);
    end
    out_ready = 1;
    tick(1);
    out_ready = 0;
    wait_ready("ready_after_hold");
    // column 3 never returns
    set_delays(5, 5);
    stuck = 3;
    out_ready = 1;
    send(8'h5A);
    k = 0;
    while (!err && k < 3 * TO) begin tick(1); k++; end
    chk("timeout_cycles", k, TO);
    chk("timeout_uin", uin, 0);
    chk("timeout_array_reset", array_reset, 1);
    chk("timeout_in_ready", in_ready, 0);
    tick(20);
    chk("timeout_sticky_err", err, 1);
    chk("timeout_stays_err", array_reset, 1);
    chk("timeout_out_valid", out_valid, 0);
    // recover and inject an illegal pair on column 5
    reset_n = 0;
    sb.delete();
    stuck = -1;
    out_ready = 0;
    set_delays(5, 5);
    tick(2);
    chk("rst2_err_clear", err, 0);
    reset_n = 1;
    wait_ready("ready_before_inject");
    inject = 5;
    tick(3);
    inject = -1;
    chk("inject_err", err, 1);
    in_valid = 1;
    in_data  = 8'hFF;
    tick(5);
    chk("inject_in_ready", in_ready, 0);
    chk("inject_uin", uin, 0);
    chk("inject_out_valid", out_valid, 0);
    chk("inject_array_reset", array_reset, 1);
    chk("inject_sticky", err, 1);
    in_valid = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
